// File: rtl/spi_flash_line_reader.sv
// rtl/spi_flash_line_reader.sv - Quad-output SPI flash line-fill read engine (0x6B fast read)
module spi_flash_line_reader #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 24
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              word_valid,
  output logic [31:0]       word_data,
  output logic              word_last,
  output logic              busy,
  output logic              spi_csb,
  output logic              spi_sck,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_in
);

  localparam int DATA_BITS = 8 * LINE_WORDS;
  localparam int MAX_BITS  = (ADDR_W > DATA_BITS) ? ADDR_W : DATA_BITS;
  localparam int CNT_W     = $clog2(MAX_BITS + 1);
  localparam int ALIGN     = $clog2(LINE_WORDS * 4);
  localparam int SR_W      = 8 + ADDR_W;

  localparam logic [7:0]        CMD_FAST_READ_QUAD = 8'h6B;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << ALIGN) - 1);

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] DATA_END   = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             half;
  logic [SR_W-1:0]  tx_sr;
  logic [31:0]      rx_sr;
  logic             word_pend;

  // Serial sequencer: half==0 marks the sck-falling (drive) edge, half==1 the sck-rising (sample) edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      half       <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      word_pend  <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_last  <= 1'b0;
      spi_csb    <= 1'b1;
      spi_sck    <= 1'b0;
      io_out     <= 4'b0000;
      io_oe      <= 4'b0000;
    end else begin
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_CMD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            tx_sr     <= {CMD_FAST_READ_QUAD, req_addr & ALIGN_MASK};
            cnt       <= '0;
            half      <= 1'b0;
            word_pend <= 1'b0;
          end
        end
        S_GAP: begin
          // Deselect time: hold the bus quiet before accepting the next line.
          spi_csb <= 1'b1;
          spi_sck <= 1'b0;
          io_oe   <= 4'b0000;
          io_out  <= 4'b0000;
          if (cnt == GAP_END) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (!half) begin
            // Drive edge: sck falls and the pins move to the current bit.
            half    <= 1'b1;
            spi_sck <= 1'b0;
            spi_csb <= 1'b0;
            case (state)
              S_CMD, S_ADDR: begin
                io_oe  <= 4'b0001;
                io_out <= {3'b000, tx_sr[SR_W-1]};
                tx_sr  <= {tx_sr[SR_W-2:0], 1'b0};
              end
              default: begin
                io_oe  <= 4'b0000;
                io_out <= 4'b0000;
              end
            endcase
            if (word_pend) begin
              word_valid <= 1'b1;
              word_data  <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
              word_last  <= (cnt == DATA_END);
              word_pend  <= 1'b0;
            end
            // The final word leaves on this edge; csb rises one edge later in GAP.
            if (state == S_DATA && cnt == DATA_END) begin
              state <= S_GAP;
              cnt   <= '0;
              half  <= 1'b0;
            end
          end else begin
            // Sample edge: sck rises, io_in is captured, and bit counting advances.
            half    <= 1'b0;
            spi_sck <= 1'b1;
            case (state)
              S_CMD: begin
                if (cnt == CMD_LAST) begin
                  state <= S_ADDR;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end
              S_ADDR: begin
                if (cnt == ADDR_LAST) begin
                  state <= S_DUMMY;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end
              S_DUMMY: begin
                if (cnt == DUMMY_LAST) begin
                  state <= S_DATA;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end
              S_DATA: begin
                // Bytes accumulate big-endian; the byte swap happens when the word is emitted.
                rx_sr <= {rx_sr[27:0], io_in};
                cnt   <= cnt + CNT_W'(1);
                if (cnt[2:0] == 3'b111) begin
                  word_pend <= 1'b1;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_line_reader.sv
// tb/tb_spi_flash_line_reader.sv - Scoreboard bench for spi_flash_line_reader
module tb_spi_flash_line_reader;

  localparam int LW = 4;
  localparam int AW = 24;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_last;
  logic          busy;
  logic          spi_csb;
  logic          spi_sck;
  logic [3:0]    io_out;
  logic [3:0]    io_oe;
  logic [3:0]    io_in;
  logic [3:0]    flash_io = 4'h0;
  logic [3:0]    rnd_io = 4'h0;
  logic          use_rnd = 1'b1;

  assign io_in = use_rnd ? rnd_io : flash_io;

  spi_flash_line_reader #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .busy(busy), .spi_csb(spi_csb), .spi_sck(spi_sck),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          at;
  } exp_word_t;

  exp_word_t   exp_q[$];
  logic [31:0] exp_wire_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Word monitor: pops the scoreboard on every word_valid pulse.
  always @(negedge aclk) begin : word_mon
    exp_word_t e;
    if (aresetn && word_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none at cycle %0d", word_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("word_data", word_data, e.data);
        check("word_last", word_last, e.last);
        check("word_time", cyc, e.at);
      end
    end
  end

  // Flash model: captures command+address on io0, returns byte = low byte of address.
  int          rises = 0;
  logic [31:0] cap = '0;

  always @(posedge spi_sck or posedge spi_csb) begin
    if (spi_csb) begin
      rises = 0;
    end else begin
      if (rises < 32) cap = {cap[30:0], io_out[0]};
      rises = rises + 1;
      if (rises == 32) begin
        if (exp_wire_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transaction actual=%h required=none", cap);
        end else begin
          check("wire_cmd_addr", cap, exp_wire_q.pop_front());
        end
      end
    end
  end

  always @(negedge spi_sck) begin : flash_out
    int i;
    logic [7:0] b;
    if (!spi_csb && rises >= 40) begin
      i = rises - 40;
      b = 8'(cap[23:0] + 24'(i / 2));
      flash_io = (i % 2 == 0) ? b[7:4] : b[3:0];
    end
  end

  // Pin discipline monitor.
  logic prev_sck = 1'b0;
  logic prev_csb = 1'b1;
  int   csb_high = 100;

  always @(negedge aclk) begin
    if (aresetn) begin
      check("oe_while_deselected", (spi_csb && io_oe != 4'h0), 1'b0);
      check("oe_in_dummy_data", (!spi_csb && !spi_sck && rises >= 32 && io_oe != 4'h0), 1'b0);
      check("sck_while_deselected", (spi_sck !== prev_sck && spi_csb && prev_csb), 1'b0);
      if (!spi_csb && prev_csb) check("csb_gap_min4", (csb_high >= 4), 1'b1);
    end
    csb_high = spi_csb ? csb_high + 1 : 0;
    prev_sck = spi_sck;
    prev_csb = spi_csb;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_word_valid"}, word_valid, 1'b0);
    check({tag, "_word_last"}, word_last, 1'b0);
    check({tag, "_word_data"}, word_data, 32'h0);
    check({tag, "_csb"}, spi_csb, 1'b1);
    check({tag, "_sck"}, spi_sck, 1'b0);
    check({tag, "_io_oe"}, io_oe, 4'h0);
    check({tag, "_io_out"}, io_out, 4'h0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 400) begin
      @(negedge aclk);
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
  endtask

  task automatic push_line(input logic [23:0] wire_addr, input logic [31:0] words[LW],
                           input int nwords, input int t0);
    exp_wire_q.push_back({8'h6B, wire_addr});
    for (int k = 0; k < nwords; k++)
      exp_q.push_back('{data: words[k], last: (k == LW - 1), at: t0 + 97 + 16 * k});
  endtask

  task automatic run_txn(input logic [23:0] addr, input logic [23:0] wire_addr,
                         input logic [31:0] words[LW], input bit poke);
    int t0;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = addr;
    t0 = cyc + 1;
    push_line(wire_addr, words, LW, t0);
    @(negedge aclk);
    req_valid = 1'b0;
    check("busy_at_t0", busy, 1'b1);
    check("ready_at_t0", req_ready, 1'b0);
    check("csb_at_t0", spi_csb, 1'b1);
    for (int c = t0 + 1; c <= t0 + 150; c++) begin
      @(negedge aclk);
      if (poke) begin
        req_valid = (c >= t0 + 100 && c < t0 + 104);
        if (c >= t0 + 100 && c < t0 + 104) check("ready_during_data", req_ready, 1'b0);
      end
      if (c == t0 + 1) begin
        check("csb_fall_t1", spi_csb, 1'b0);
        check("sck_low_t1", spi_sck, 1'b0);
      end
      if (c == t0 + 2) check("sck_rise_t2", spi_sck, 1'b1);
      if (c == t0 + 145) check("csb_low_t145", spi_csb, 1'b0);
      if (c == t0 + 146) check("csb_rise_t146", spi_csb, 1'b1);
      if (c == t0 + 149) check("ready_low_t149", req_ready, 1'b0);
      if (c == t0 + 150) begin
        check("ready_high_t150", req_ready, 1'b1);
        check("busy_low_t150", busy, 1'b0);
      end
    end
    req_valid = 1'b0;
  endtask

  logic [31:0] line_100[LW];
  logic [31:0] line_120[LW];
  logic [31:0] line_140[LW];
  logic [31:0] line_150[LW];

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    int t0;
    line_100 = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    line_120 = '{32'h23222120, 32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C};
    line_140 = '{32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};
    line_150 = '{32'h53525150, 32'h57565554, 32'h5B5A5958, 32'h5F5E5D5C};

    // Reset held with random inputs.
    repeat (6) begin
      @(negedge aclk);
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 24'($urandom);
      rnd_io    = 4'($urandom);
    end
    @(negedge aclk);
    check_reset_values("rst");
    req_valid = 1'b0;
    use_rnd   = 1'b0;
    aresetn   = 1'b1;
    @(negedge aclk);
    check("release_ready", req_ready, 1'b1);
    check("release_busy", busy, 1'b0);
    check("release_csb", spi_csb, 1'b1);

    // Single fill, alignment with busy poke, another aligned line.
    run_txn(24'h000100, 24'h000100, line_100, 1'b0);
    run_txn(24'h00010C, 24'h000100, line_100, 1'b1);
    run_txn(24'h00012F, 24'h000120, line_120, 1'b0);

    // Reset in the middle of DATA after word 1.
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 24'h000140;
    t0 = cyc + 1;
    push_line(24'h000140, line_140, 2, t0);
    @(negedge aclk);
    req_valid = 1'b0;
    while (cyc < t0 + 115) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_reset_values("abort");
    req_valid = 1'b1;
    req_addr  = 24'h000150;
    repeat (4) @(negedge aclk);
    check_reset_values("abort_hold");
    t0 = cyc + 1;
    push_line(24'h000150, line_150, LW, t0);
    aresetn = 1'b1;
    @(negedge aclk);
    req_valid = 1'b0;
    check("accept_on_release", busy, 1'b1);
    check("ready_after_release", req_ready, 1'b0);
    while (cyc < t0 + 150) @(negedge aclk);
    check("ready_after_line", req_ready, 1'b1);

    repeat (5) @(negedge aclk);
    check("words_left", exp_q.size(), 0);
    check("wire_left", exp_wire_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_flash_line_reader.md
# spi_flash_line_reader

Quad-output SPI flash read engine that sits directly downstream of the SPI cache controller and drives the external flash pins. On a line-fill request it issues a Fast Read Quad Output (0x6B) transaction, deserializes the returned nibbles into 32-bit words, and streams one cache line back to the cache. All logic runs on the AXI clock; the flash serial clock is a registered divide-by-two of it.

## Interface
- LINE_WORDS, 4: 32-bit words per line fill (power of two, 1..16).
- ADDR_W, 24: flash byte-address width sent on the wire.

- aclk  in  1  system clock.
- aresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  line-fill request.
- req_ready  out  1  high only in IDLE; handshake on req_valid & req_ready.
- req_addr  in  ADDR_W  byte address; low log2(LINE_WORDS*4) bits are forced to 0.
- word_valid  out  1  one-cycle pulse per deserialized word; no backpressure.
- word_data  out  32  line word, little-endian byte packing.
- word_last  out  1  high with the final word_valid of the line.
- busy  out  1  high from the accepting edge until the return to IDLE.
- spi_csb  out  1  flash chip select, active low.
- spi_sck  out  1  flash clock, mode 0 (idles low).
- io_out  out  4  pin output data.
- io_oe  out  4  pin output enables (1 = drive).
- io_in  in  4  pin input data.

## Operation
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> GAP -> IDLE.
- Every sck period is 2 aclk cycles: half-phase 0 sck=0, half-phase 1 sck=1. Outputs change only when sck goes 0; io_in is sampled on the aclk edge that drives sck 0->1.
- IDLE: csb=1, sck=0, io_oe=0000, req_ready=1. Handshake latches the aligned address and enters CMD.
- CMD: 8 sck periods, 0x6B MSB first on io_out[0]; io_oe=0001; io_out[3:1]=0.
- ADDR: ADDR_W sck periods, address MSB first on io_out[0]; io_oe=0001.
- DUMMY: 8 sck periods, io_oe=0000.
- DATA: 8*LINE_WORDS sck periods, io_oe=0000; each sample takes one nibble from io_in[3:0]. Per byte, the first nibble is bits [7:4]. Byte n of a word lands in word_data[8n+7:8n].
- After the 8th nibble of a word, word_valid pulses for one cycle with the assembled word; word_last is set on word LINE_WORDS-1.
- GAP: csb=1, sck=0 for 4 aclk cycles (flash deselect time), then IDLE.
- req_valid outside IDLE is ignored; it is not queued.
- Counters: a bit counter sized for max(ADDR_W, 8*LINE_WORDS) and a 1-bit half-phase toggle. No arithmetic wrap beyond a single line.

## Timing
- Reset values: req_ready=1, busy=0, word_valid=0, word_last=0, word_data=0, spi_csb=1, spi_sck=0, io_oe=0000, io_out=0000. State is IDLE.
- Let T0 be the accepting edge. csb falls at T0+1, and the first sck rise is at T0+2.
- Word k (0-based) has word_valid high in the cycle after edge T0+1+2*(8+ADDR_W+8)+16*(k+1). With ADDR_W=24 that is 97+16k cycles after T0.
- csb rises on the edge after the last word_valid. req_ready returns 4 cycles later.
- Minimum request-to-request spacing with defaults: 1+80+64+1+4 = 150 cycles.
- Asserting aresetn low mid-transaction immediately forces all reset values, including csb=1, and aborts the line with no further word_valid. After release the block is in IDLE.
- Reset release with req_valid already high: the request is accepted on the first clock edge after release.

## Test plan
- Reset: hold aresetn low with random inputs -> all outputs at reset values. Release -> req_ready=1 on the first edge.
- Single fill: flash model bytes 0x00..0x0F at 0x000100, req_addr=0x000100 -> io0 carries 0x6B then 0x000100 -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C at T0+97/113/129/145, with word_last on the 4th.
- Alignment: req_addr=0x00010C -> identical wire address 0x000100 and identical words.
- Busy ignore: pulse req_valid during DATA -> no handshake, no second transaction. Then issue a new request after req_ready rises -> a clean second transaction with csb high for at least 4 cycles between the two.
- Reset mid-DATA: assert aresetn after word 1 -> csb=1 and sck=0 at once, no more word_valid. After release, the next request yields a correct full line.
- Pin discipline: check throughout -> io_oe is never nonzero while csb=1 or during DUMMY/DATA, and sck toggles only while csb=0.
